// File: rtl/fibo_pkg.sv
// Shared types and defaults for the Fibonacci engine: state encoding, default widths,
// and the saturation helper used when FIBO_SATURATE_EN is defined.
package fibo_pkg;

  localparam int FIBO_WIDTH = 16;
  localparam int FIBO_IDX_W = 5;
  // Widest datapath the saturation helper handles; WIDTH must not exceed it.
  localparam int FIBO_MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } fibo_state_e;

  // Callers truncate the result to their own width, so all-ones survives as all-ones.
  function automatic logic [FIBO_MAX_W-1:0] fibo_saturate(
    input logic [FIBO_MAX_W-1:0] value,
    input logic                  ovf
  );
    return ovf ? {FIBO_MAX_W{1'b1}} : value;
  endfunction

endpackage

// File: rtl/fibonacci_engine_if.sv
// Start/done handshake between a controller (master) and the Fibonacci engine (slave).
// The engine samples start only while idle; results stay valid until the next done.
interface fibonacci_engine_if #(
  parameter int WIDTH = 16,
  parameter int IDX_W = 5
);

  logic             start;
  logic [IDX_W-1:0] n_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] fibo_out;
  logic             overflow;

  modport master (
    output start, n_in,
    input  busy, done, fibo_out, overflow
  );

  modport slave (
    input  start, n_in,
    output busy, done, fibo_out, overflow
  );

endinterface

// File: rtl/fibo_datapath.sv
// Two-term Fibonacci iterator with exact overflow tracking and a down-counting index.
// One term per step; load and step come from the controlling FSM, no backpressure.
module fibo_datapath
  import fibo_pkg::*;
#(
  parameter int WIDTH = FIBO_WIDTH,
  parameter int IDX_W = FIBO_IDX_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             step,
  input  logic [IDX_W-1:0] n_in,
  output logic [WIDTH-1:0] a_val,
  output logic             a_ovf,
  output logic             cnt_zero
);

  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             a_ovf_q, a_ovf_d, b_ovf_q, b_ovf_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   sum;

  assign sum = {1'b0, a_q} + {1'b0, b_q};

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    a_ovf_d = a_ovf_q;
    b_ovf_d = b_ovf_q;
    cnt_d   = cnt_q;
    if (load) begin
      a_d     = '0;
      b_d     = WIDTH'(1);
      a_ovf_d = 1'b0;
      b_ovf_d = 1'b0;
      cnt_d   = n_in;
    end else if (step) begin
      // b runs one term ahead, so its overflow reaches a only when that term shifts down.
      a_d     = b_q;
      b_d     = sum[WIDTH-1:0];
      a_ovf_d = b_ovf_q;
      b_ovf_d = a_ovf_q | b_ovf_q | sum[WIDTH];
      cnt_d   = cnt_q - IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q     <= '0;
      b_q     <= '0;
      a_ovf_q <= 1'b0;
      b_ovf_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      a_ovf_q <= a_ovf_d;
      b_ovf_q <= b_ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign a_val    = a_q;
  assign a_ovf    = a_ovf_q;
  assign cnt_zero = (cnt_q == '0);

endmodule

// File: rtl/fibonacci_engine.sv
// Handshaked F(n) generator: done pulses n+1 cycles after start is accepted; start is ignored while busy.
// FIBO_SATURATE_EN: clamp fibo_out to all ones when the result overflows WIDTH bits.
module fibonacci_engine
  import fibo_pkg::*;
#(
  parameter int WIDTH = FIBO_WIDTH,
  parameter int IDX_W = FIBO_IDX_W
) (
  input  logic             clk,
  input  logic             reset_n,
  fibonacci_engine_if.slave bus
);

  fibo_state_e      state_q, state_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] fibo_out_q, fibo_out_d;
  logic             overflow_q, overflow_d;

  logic             load, step;
  logic [WIDTH-1:0] dp_a;
  logic             dp_a_ovf;
  logic             cnt_zero;
  logic [WIDTH-1:0] result;

  fibo_datapath #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_datapath (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (load),
    .step     (step),
    .n_in     (bus.n_in),
    .a_val    (dp_a),
    .a_ovf    (dp_a_ovf),
    .cnt_zero (cnt_zero)
  );

`ifdef FIBO_SATURATE_EN
  assign result = WIDTH'(fibo_saturate(FIBO_MAX_W'(dp_a), dp_a_ovf));
`else
  assign result = dp_a;
`endif

  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    fibo_out_d = fibo_out_q;
    overflow_d = overflow_q;
    load       = 1'b0;
    step       = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          load    = 1'b1;
          busy_d  = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        if (cnt_zero) begin
          fibo_out_d = result;
          overflow_d = dp_a_ovf;
          done_d     = 1'b1;
          state_d    = DONE;
        end else begin
          step = 1'b1;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      fibo_out_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      fibo_out_q <= fibo_out_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.fibo_out = fibo_out_q;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_fibonacci_engine.sv
// Directed bench for fibonacci_engine with a cycle-level reference model and literal expectations.
// Expected values follow FIBO_SATURATE_EN when it is defined for the build.
module tb_fibonacci_engine;

`ifdef FIBO_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  fibonacci_engine_if #(.WIDTH(16), .IDX_W(5)) bus ();

  fibonacci_engine #(.WIDTH(16), .IDX_W(5)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint fib(input int n);
    longint a = 0;
    longint b = 1;
    longint t;
    for (int i = 0; i < n; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // {overflow, fibo_out} that a completed run of index n must report.
  function automatic logic [16:0] expect_fib(input int n);
    longint f = fib(n);
    logic   ovf = (f >= 65536);
    logic [15:0] v = (ovf && SAT) ? 16'hFFFF : 16'(f % 65536);
    return {ovf, v};
  endfunction

  // Reference model: a run accepted at edge k is busy after edges k..k+n+1, done after edge k+n+1.
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  logic        m_ovf = 1'b0;
  logic [15:0] m_out = '0;
  int          m_phase = 0;
  int          m_n = 0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_busy  <= 1'b0;
      m_done  <= 1'b0;
      m_ovf   <= 1'b0;
      m_out   <= '0;
      m_phase <= 0;
      m_n     <= 0;
    end else if (!m_busy) begin
      m_done <= 1'b0;
      if (bus.start) begin
        m_busy  <= 1'b1;
        m_phase <= 0;
        m_n     <= int'(bus.n_in);
      end
    end else begin
      m_phase <= m_phase + 1;
      m_done  <= (m_phase + 1 == m_n + 1);
      if (m_phase + 1 == m_n + 1) {m_ovf, m_out} <= expect_fib(m_n);
      if (m_phase + 1 == m_n + 2) m_busy <= 1'b0;
    end
  end

  always @(negedge clk) begin
    check("model_busy", 64'(bus.busy), 64'(m_busy));
    check("model_done", 64'(bus.done), 64'(m_done));
    check("model_fibo_out", 64'(bus.fibo_out), 64'(m_out));
    check("model_overflow", 64'(bus.overflow), 64'(m_ovf));
  end

  task automatic run(input int n, input int exp_val, input bit exp_ovf, input bit poke);
    int lat = 0;
    int w = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.n_in  = 5'(n);
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    while (lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (poke && lat >= 2 && lat <= 6) begin
        bus.start = lat[0];
        bus.n_in  = 5'(lat * 7);
      end
      if (poke && lat == 7) bus.start = 1'b0;
      if (bus.done) break;
    end
    check($sformatf("latency_n%0d", n), 64'(lat), 64'(n + 1));
    check($sformatf("fibo_out_n%0d", n), 64'(bus.fibo_out), 64'(exp_val));
    check($sformatf("overflow_n%0d", n), 64'(bus.overflow), 64'(exp_ovf));
    while (bus.busy && w < 10) begin
      @(negedge clk);
      w++;
    end
    check($sformatf("idle_after_n%0d", n), 64'(bus.busy), 64'(0));
  endtask

  initial begin
    int dones;
    int last;
    int low;
    int w;
    bus.start = 1'b0;
    bus.n_in  = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(bus.busy), 64'(0));
    check("reset_done", 64'(bus.done), 64'(0));
    check("reset_fibo_out", 64'(bus.fibo_out), 64'(0));
    check("reset_overflow", 64'(bus.overflow), 64'(0));
    reset_n = 1'b1;

    run(0, 0, 1'b0, 1'b0);
    run(1, 1, 1'b0, 1'b0);
    run(10, 55, 1'b0, 1'b1);
    dones = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    check("no_extra_done_n10", 64'(dones), 64'(0));
    check("held_n10", 64'(bus.fibo_out), 64'(55));

    run(24, 46368, 1'b0, 1'b0);
    run(25, SAT ? 65535 : 9489, 1'b1, 1'b0);
    run(31, SAT ? 65535 : 35549, 1'b1, 1'b0);
    dones = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    check("idle_no_done", 64'(dones), 64'(0));
    check("idle_hold_value", 64'(bus.fibo_out), 64'(SAT ? 65535 : 35549));
    check("idle_hold_ovf", 64'(bus.overflow), 64'(1));

    // start held high: accepted at i=1,7,13,19; done at i=5,11,17; busy low at i=6,12,18
    @(negedge clk);
    bus.start = 1'b1;
    bus.n_in  = 5'd3;
    dones = 0;
    last  = -1;
    low   = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.done) begin
        dones++;
        if (last >= 0) check("held_period", 64'(i - last), 64'(6));
        last = i;
        check("held_value", 64'(bus.fibo_out), 64'(2));
      end
      if (!bus.busy) low++;
    end
    check("held_done_count", 64'(dones), 64'(3));
    check("held_busy_low_cycles", 64'(low), 64'(3));
    bus.start = 1'b0;
    w = 0;
    while (bus.busy && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("held_drain", 64'(bus.busy), 64'(0));

    // Abandon an n=20 run with a mid-cycle reset.
    @(negedge clk);
    bus.start = 1'b1;
    bus.n_in  = 5'd20;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("async_busy", 64'(bus.busy), 64'(0));
    check("async_done", 64'(bus.done), 64'(0));
    check("async_fibo_out", 64'(bus.fibo_out), 64'(0));
    check("async_overflow", 64'(bus.overflow), 64'(0));
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    dones = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    check("no_done_after_reset", 64'(dones), 64'(0));
    run(20, 6765, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fibonacci_engine.md
# fibonacci_engine

Parametrised, handshaked Fibonacci sequence generator: on a start request it latches an index n and iterates a two-register datapath to produce F(n), with F(0)=0 and F(1)=1. It replaces the fixed 16-bit / 5-bit-index calculator with configurable widths, explicit busy/done signalling, a held result, and overflow detection. It sits as a slave compute unit behind a simple start/done controller.

## Interface
- WIDTH, 16: result and datapath width in bits (≥2).
- IDX_W, 5: index width in bits; n ranges 0..2^IDX_W−1.
- clk  in  1  rising-edge clock.
- reset_n  in  1  reset, asynchronous, active-low.
- start  in  1  request; sampled only in IDLE.
- n_in  in  IDX_W  requested index; latched when start is accepted.
- busy  out  1  high in CALC and DONE.
- done  out  1  one-cycle pulse marking a new valid result.
- fibo_out  out  WIDTH  F(n) of the last completed run; held until the next completion.
- overflow  out  1  true F(n) ≥ 2^WIDTH for the last completed run; held with fibo_out.

## Operation
- States: IDLE, CALC, DONE. Reset → IDLE.
- IDLE: if start=1 at the edge, latch cnt←n_in, a←0, b←1, a_ovf←0, b_ovf←0, go to CALC. Otherwise stay.
- CALC, cnt≠0: a←b, b←a+b mod 2^WIDTH, a_ovf←b_ovf, b_ovf←a_ovf|b_ovf|carry(a+b), cnt←cnt−1.
- CALC, cnt=0: fibo_out←a (or the saturated value, see Configuration), overflow←a_ovf, done←1, go to DONE.
- DONE: done←0, go to IDLE. start is not sampled in DONE.
- start in CALC or DONE is ignored and has no side effects. n_in changes after acceptance do not affect the run.
- Overflow tracking is exact. Carries from b (one term ahead) reach a_ovf only when that term becomes a, so F(n) fitting exactly in WIDTH reports overflow=0.
- fibo_out and overflow change only at the DONE-entry edge or at reset.

## Timing
- Reset values: busy=0, done=0, fibo_out=0, overflow=0; internal state IDLE, registers cleared.
- start accepted at edge k → done high during the cycle after edge k+n+1. Latency is n+1 cycles, so n=0 gives done 1 cycle after acceptance.
- busy rises after edge k and falls after edge k+n+2.
- With start held high, the next acceptance happens at the first IDLE edge after DONE. Back-to-back period is n+3 cycles.
- reset_n asserted in any state: immediate return to reset values. The run is abandoned, and no done is produced after release.
- Reset release in the same cycle as start: start is sampled at the first edge with reset_n high.

## Configuration
- FIBO_SATURATE_EN defined: when overflow=1, fibo_out = all ones (2^WIDTH−1).
- Undefined: fibo_out = F(n) mod 2^WIDTH.
- The overflow output behaves identically in both builds.

## Structure
- Shared package fibo_pkg holds:
  - the state enum (IDLE, CALC, DONE),
  - default WIDTH/IDX_W constants,
  - a saturation helper function.
- One sub-module is natural: fibo_datapath, containing the a/b registers, carry/overflow tracking and cnt. The top holds the FSM and output registers.

## Test plan
- Reset, then n=0 start → done one cycle after acceptance, fibo_out=0, overflow=0. Then n=1 → fibo_out=1, latency 2.
- n=10 → fibo_out=55 after 11 cycles. Toggle n_in and start during CALC → result unchanged, no extra done.
- n=24 → fibo_out=46368, overflow=0. n=25 → overflow=1; fibo_out=9489 without FIBO_SATURATE_EN, 65535 with it.
- n=31 → fibo_out=35549 (unsaturated), overflow=1. Result holds for 20 idle cycles with no done.
- start held high with n=3 → done pulses every 6 cycles, fibo_out=2 each time, busy low exactly one cycle between runs.
- Assert reset_n mid-CALC at n=20 → outputs return to 0 asynchronously. After release no done occurs until a new start, and a fresh n=20 gives 6765.
